// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared encodings and types for the CSR access unit
package csr_pkg;

   localparam int XLEN_DEF   = 64;
   localparam int ADDR_W_DEF = 12;

   localparam logic [2:0] F3_RW  = 3'b001;
   localparam logic [2:0] F3_RS  = 3'b010;
   localparam logic [2:0] F3_RC  = 3'b011;
   localparam logic [2:0] F3_RWI = 3'b101;
   localparam logic [2:0] F3_RSI = 3'b110;
   localparam logic [2:0] F3_RCI = 3'b111;

   localparam logic [1:0] PRIV_U = 2'b00;
   localparam logic [1:0] PRIV_S = 2'b01;
   localparam logic [1:0] PRIV_M = 2'b11;

   typedef enum logic [1:0] {
      CSR_OP_NONE = 2'b00,
      CSR_OP_RW   = 2'b01,
      CSR_OP_RS   = 2'b10,
      CSR_OP_RC   = 2'b11
   } csr_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      RESP  = 2'b11
   } csr_access_state_t;

   typedef logic [ADDR_W_DEF-1:0] csr_addr_t;

   // Register and immediate forms share an operation; funct3[2] selects the operand source.
   function automatic csr_op_t decode_op(input logic [2:0] funct3);
      case (funct3)
         F3_RW, F3_RWI: decode_op = CSR_OP_RW;
         F3_RS, F3_RSI: decode_op = CSR_OP_RS;
         F3_RC, F3_RCI: decode_op = CSR_OP_RC;
         default:       decode_op = CSR_OP_NONE;
      endcase
   endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// rtl/csr_access_unit_if.sv - execute request, writeback response and CSR file signals
interface csr_access_unit_if #(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 12
);
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [4:0]        req_rs1_idx;
   logic [XLEN-1:0]   req_rs1_val;
   logic [4:0]        req_rd;
   logic [1:0]        req_priv;
   logic              flush;
   logic [ADDR_W-1:0] csr_addr_read;
   logic [XLEN-1:0]   csr_rdata;
   logic [ADDR_W-1:0] csr_addr_write;
   logic [XLEN-1:0]   csr_wdata;
   logic              csr_we;
   logic              resp_valid;
   logic              resp_ready;
   logic [XLEN-1:0]   resp_data;
   logic [4:0]        resp_rd;
   logic              resp_illegal;

   modport master (
      output req_valid, req_funct3, req_addr, req_rs1_idx, req_rs1_val, req_rd, req_priv,
      output flush, csr_rdata, resp_ready,
      input  req_ready, csr_addr_read, csr_addr_write, csr_wdata, csr_we,
      input  resp_valid, resp_data, resp_rd, resp_illegal
   );

   modport slave (
      input  req_valid, req_funct3, req_addr, req_rs1_idx, req_rs1_val, req_rd, req_priv,
      input  flush, csr_rdata, resp_ready,
      output req_ready, csr_addr_read, csr_addr_write, csr_wdata, csr_we,
      output resp_valid, resp_data, resp_rd, resp_illegal
   );
endinterface

// File: rtl/csr_op_alu.sv
// rtl/csr_op_alu.sv - new CSR value and write-intent for RW/RS/RC operations
module csr_op_alu
   import csr_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  csr_op_t         op,
   input  logic [XLEN-1:0] old_val,
   input  logic [XLEN-1:0] operand,
   input  logic [4:0]      src_idx,
   output logic [XLEN-1:0] new_val,
   output logic            write_intended
);

   // Set/clear with x0 or zimm=0 are pure reads, even if the register value is nonzero.
   always_comb begin
      new_val        = old_val;
      write_intended = 1'b0;
      case (op)
         CSR_OP_RW: begin
            new_val        = operand;
            write_intended = 1'b1;
         end
         CSR_OP_RS: begin
            new_val        = old_val | operand;
            write_intended = |src_idx;
         end
         CSR_OP_RC: begin
            new_val        = old_val & ~operand;
            write_intended = |src_idx;
         end
         default: begin
            new_val        = old_val;
            write_intended = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - CSR instruction sequencer between execute and the CSR register file
// Defining CSR_ACCESS_PERF_EN adds the csr_op_count retired-operation counter.
module csr_access_unit
   import csr_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic clk,
   input  logic reset,
   csr_access_unit_if.slave bus
`ifdef CSR_ACCESS_PERF_EN
   ,
   output logic [63:0] csr_op_count
`endif
);

   csr_access_state_t state;
   csr_op_t           lat_op;
   logic [ADDR_W-1:0] lat_addr;
   logic [XLEN-1:0]   lat_operand;
   logic [4:0]        lat_src_idx;
   logic [4:0]        lat_rd;
   logic [1:0]        lat_priv;
   logic [XLEN-1:0]   old_q;
   logic              illegal_q;

   logic [XLEN-1:0]   alu_new;
   logic              alu_write;
   logic              rd_illegal;

   // The ALU sees the live read data so the write can be registered at the end of READ.
   csr_op_alu #(.XLEN(XLEN)) u_alu (
      .op             (lat_op),
      .old_val        (bus.csr_rdata),
      .operand        (lat_operand),
      .src_idx        (lat_src_idx),
      .new_val        (alu_new),
      .write_intended (alu_write)
   );

   always_comb begin
      rd_illegal = 1'b0;
      if (lat_addr[9:8] > lat_priv)
         rd_illegal = 1'b1;
      if ((lat_addr[11:10] == 2'b11) && alu_write)
         rd_illegal = 1'b1;
      if (lat_op == CSR_OP_NONE)
         rd_illegal = 1'b1;
   end

   assign bus.req_ready = (state == IDLE) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         lat_op             <= CSR_OP_NONE;
         lat_addr           <= '0;
         lat_operand        <= '0;
         lat_src_idx        <= '0;
         lat_rd             <= '0;
         lat_priv           <= '0;
         old_q              <= '0;
         illegal_q          <= 1'b0;
         bus.csr_addr_read  <= '0;
         bus.csr_addr_write <= '0;
         bus.csr_wdata      <= '0;
         bus.csr_we         <= 1'b0;
         bus.resp_valid     <= 1'b0;
         bus.resp_data      <= '0;
         bus.resp_rd        <= '0;
         bus.resp_illegal   <= 1'b0;
      end else begin
         bus.csr_we         <= 1'b0;
         bus.csr_addr_write <= '0;
         bus.csr_wdata      <= '0;
         case (state)
            IDLE: begin
               if (bus.req_valid && !bus.flush) begin
                  lat_op            <= decode_op(bus.req_funct3);
                  lat_addr          <= bus.req_addr;
                  lat_operand       <= bus.req_funct3[2] ? {{(XLEN-5){1'b0}}, bus.req_rs1_idx}
                                                         : bus.req_rs1_val;
                  lat_src_idx       <= bus.req_rs1_idx;
                  lat_rd            <= bus.req_rd;
                  lat_priv          <= bus.req_priv;
                  bus.csr_addr_read <= bus.req_addr;
                  state             <= READ;
               end
            end
            READ: begin
               bus.csr_addr_read <= '0;
               if (bus.flush) begin
                  state <= IDLE;
               end else begin
                  old_q     <= bus.csr_rdata;
                  illegal_q <= rd_illegal;
                  if (alu_write && !rd_illegal) begin
                     bus.csr_we         <= 1'b1;
                     bus.csr_addr_write <= lat_addr;
                     bus.csr_wdata      <= alu_new;
                  end
                  state <= WRITE;
               end
            end
            WRITE: begin
               bus.resp_valid   <= 1'b1;
               bus.resp_data    <= illegal_q ? '0 : old_q;
               bus.resp_rd      <= lat_rd;
               bus.resp_illegal <= illegal_q;
               state            <= RESP;
            end
            RESP: begin
               // A flush discards the response even if writeback is ready in the same cycle.
               if (bus.flush || bus.resp_ready) begin
                  bus.resp_valid   <= 1'b0;
                  bus.resp_data    <= '0;
                  bus.resp_rd      <= '0;
                  bus.resp_illegal <= 1'b0;
                  state            <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CSR_ACCESS_PERF_EN
   always_ff @(posedge clk) begin
      if (reset)
         csr_op_count <= '0;
      else if ((state == RESP) && bus.resp_ready && !bus.flush && !bus.resp_illegal)
         csr_op_count <= csr_op_count + 64'd1;
   end
`endif

endmodule

// File: tb/tb_csr_access_unit.sv
// tb/tb_csr_access_unit.sv - directed and randomized checks of csr_access_unit against a reference model
module tb_csr_access_unit;
   import csr_pkg::*;

   localparam int XLEN   = 64;
   localparam int ADDR_W = 12;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   csr_access_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

   logic [ADDR_W-1:0] cur_addr;
   logic [XLEN-1:0]   cur_old;
   assign bus.csr_rdata = (bus.csr_addr_read == cur_addr) ? cur_old : 64'hBAD0_BAD0_BAD0_BAD0;

`ifdef CSR_ACCESS_PERF_EN
   logic [63:0] csr_op_count;
   logic [63:0] exp_count = '0;
`endif

   csr_access_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
`ifdef CSR_ACCESS_PERF_EN
      ,
      .csr_op_count (csr_op_count)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Architectural CSR instruction semantics computed straight from funct3.
   function automatic void model(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] idx,
                                 input logic [63:0] val, input logic [1:0] priv, input logic [63:0] old,
                                 output bit e_we, output logic [63:0] e_wdata,
                                 output logic [63:0] e_rdata, output bit e_ill);
      logic [63:0] src;
      bit          wants_write;
      src = f3[2] ? 64'(idx) : val;
      wants_write = (f3[1:0] == 2'b01) || (idx != 5'd0);
      case (f3[1:0])
         2'b01:   e_wdata = src;
         2'b10:   e_wdata = old | src;
         default: e_wdata = old & ~src;
      endcase
      e_ill   = (addr[9:8] > priv) || ((addr[11:10] == 2'b11) && wants_write);
      e_we    = wants_write && !e_ill;
      e_rdata = e_ill ? 64'd0 : old;
   endfunction

   // flush_at: 0 none, 1 during READ, 2 during WRITE, 3 during RESP
   task automatic do_req(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] idx,
                         input logic [63:0] val, input logic [4:0] rd, input logic [1:0] priv,
                         input logic [63:0] old, input int hold, input int flush_at);
      bit          e_we, e_ill;
      logic [63:0] e_wdata, e_rdata;
      int          waited;
      model(f3, addr, idx, val, priv, old, e_we, e_wdata, e_rdata, e_ill);
      cur_addr = addr;
      cur_old  = old;
      waited   = 0;
      while (bus.req_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("req_ready_wait", bus.req_ready, 1);
      bus.req_valid   = 1'b1;
      bus.req_funct3  = f3;
      bus.req_addr    = addr;
      bus.req_rs1_idx = idx;
      bus.req_rs1_val = val;
      bus.req_rd      = rd;
      bus.req_priv    = priv;
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("read_addr", bus.csr_addr_read, addr);
      check("ready_busy", bus.req_ready, 0);
      check("we_in_read", bus.csr_we, 0);
      if (flush_at == 1) bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      if (flush_at == 1) begin
         check("flush_read_we", bus.csr_we, 0);
         check("flush_read_ready", bus.req_ready, 1);
         check("flush_read_addr", bus.csr_addr_read, 0);
         @(negedge clk);
         check("flush_read_we2", bus.csr_we, 0);
         check("flush_read_resp", bus.resp_valid, 0);
         return;
      end
      check("we", bus.csr_we, e_we);
      check("waddr", bus.csr_addr_write, e_we ? 64'(addr) : 64'd0);
      check("wdata", bus.csr_wdata, e_we ? e_wdata : 64'd0);
      check("read_addr_cleared", bus.csr_addr_read, 0);
      if (flush_at == 2) bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("we_one_cycle", bus.csr_we, 0);
      for (int h = 0; h <= hold; h++) begin
         check("resp_valid", bus.resp_valid, 1);
         check("resp_data", bus.resp_data, e_rdata);
         check("resp_rd", bus.resp_rd, rd);
         check("resp_illegal", bus.resp_illegal, e_ill);
         check("ready_in_resp", bus.req_ready, 0);
`ifdef CSR_ACCESS_PERF_EN
         check("count_hold", csr_op_count, exp_count);
`endif
         if (h < hold) @(negedge clk);
      end
      if (flush_at == 3) begin
         bus.flush = 1'b1;
         @(negedge clk);
         bus.flush = 1'b0;
         check("flush_resp_valid", bus.resp_valid, 0);
         check("flush_resp_ready", bus.req_ready, 1);
`ifdef CSR_ACCESS_PERF_EN
         check("flush_resp_count", csr_op_count, exp_count);
`endif
         return;
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
`ifdef CSR_ACCESS_PERF_EN
      if (!e_ill) exp_count = exp_count + 64'd1;
      check("op_count", csr_op_count, exp_count);
`endif
      check("resp_done", bus.resp_valid, 0);
      check("ready_after", bus.req_ready, 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0]  f3_tab [0:5];
      logic [1:0]  pr_tab [0:2];
      logic [2:0]  r_f3;
      logic [4:0]  r_idx;
      int          r_flush;
      f3_tab[0] = F3_RW;  f3_tab[1] = F3_RS;  f3_tab[2] = F3_RC;
      f3_tab[3] = F3_RWI; f3_tab[4] = F3_RSI; f3_tab[5] = F3_RCI;
      pr_tab[0] = PRIV_U; pr_tab[1] = PRIV_S; pr_tab[2] = PRIV_M;

      reset = 1'b1;
      cur_addr = '0; cur_old = '0;
      bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_addr = '0; bus.req_rs1_idx = '0;
      bus.req_rs1_val = '0; bus.req_rd = '0; bus.req_priv = '0; bus.flush = 1'b0;
      bus.resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_we", bus.csr_we, 0);
      check("rst_read_addr", bus.csr_addr_read, 0);
      check("rst_resp_data", bus.resp_data, 0);
`ifdef CSR_ACCESS_PERF_EN
      check("rst_count", csr_op_count, 0);
`endif
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_rst", bus.req_ready, 1);

      do_req(F3_RW,  12'h340, 5'd1, 64'hDEAD, 5'd10, PRIV_M, 64'h5,    0, 0);
      do_req(F3_RS,  12'h300, 5'd0, 64'hFFFF, 5'd11, PRIV_M, 64'h1888, 0, 0);
      do_req(F3_RCI, 12'h340, 5'h8, 64'h1234, 5'd12, PRIV_M, 64'hF,    0, 0);
      do_req(F3_RW,  12'hF14, 5'd3, 64'h77,   5'd13, PRIV_M, 64'h1234, 0, 0);
      do_req(F3_RS,  12'h300, 5'd0, 64'h0,    5'd14, PRIV_U, 64'h42,   0, 0);
      do_req(F3_RW,  12'h341, 5'd2, 64'hABC,  5'd15, PRIV_M, 64'h99,   0, 1);
      do_req(F3_RSI, 12'h344, 5'h3, 64'h0,    5'd16, PRIV_M, 64'h10,   5, 0);
      do_req(F3_RW,  12'h105, 5'd4, 64'h5555, 5'd17, PRIV_S, 64'h1,    0, 2);
      do_req(F3_RC,  12'h105, 5'd4, 64'h1,    5'd18, PRIV_S, 64'h3,    1, 3);

      // Flush while idle must not accept the request.
      bus.req_valid = 1'b1; bus.flush = 1'b1; bus.req_funct3 = F3_RW; bus.req_addr = 12'h340;
      @(negedge clk);
      bus.req_valid = 1'b0; bus.flush = 1'b0;
      check("idle_flush_ready", bus.req_ready, 1);
      check("idle_flush_read", bus.csr_addr_read, 0);

      // Reset during READ aborts with no write.
      cur_addr = 12'h340; cur_old = 64'h1;
      bus.req_valid = 1'b1; bus.req_rs1_idx = 5'd1; bus.req_rs1_val = 64'hF0; bus.req_priv = PRIV_M;
      @(negedge clk);
      bus.req_valid = 1'b0;
      reset = 1'b1;
      check("rst_mid_ready", bus.req_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      check("rst_mid_we", bus.csr_we, 0);
      check("rst_mid_read", bus.csr_addr_read, 0);
      @(negedge clk);
      check("rst_mid_we2", bus.csr_we, 0);
      check("rst_mid_ready2", bus.req_ready, 1);
`ifdef CSR_ACCESS_PERF_EN
      exp_count = '0;
      check("rst_mid_count", csr_op_count, exp_count);
`endif

      for (int i = 0; i < 40; i++) begin
         r_f3    = f3_tab[$urandom_range(0, 5)];
         r_idx   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         r_flush = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
         do_req(r_f3, 12'($urandom), r_idx, {$urandom, $urandom}, 5'($urandom),
                pr_tab[$urandom_range(0, 2)], {$urandom, $urandom},
                int'($urandom_range(0, 2)), r_flush);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
